// File: rtl/bb_quantizer_agc.sv
// bb_quantizer_agc: digital gain, 3-bit sign-magnitude quantizer and windowed AGC for the baseband sum
//   in : clk, rst (async, active-high), in_valid, real_in/imag_in [15:0] signed,
//        agc_en (1 = AGC owns the gain), gain_manual [11:0] unsigned Q4.8
//   out: out_valid, real_out/imag_out [2:0] {sign,mag[1:0]}, gain_out [11:0] Q4.8, agc_locked
module bb_quantizer_agc #(
  parameter int THR_SHIFT  = 12,
  parameter int WIN_LOG2   = 10,
  parameter int TARGET_CNT = 676,
  parameter int HYST       = 32,
  parameter int GAIN_INIT  = 256,
  parameter int GAIN_STEP  = 8,
  parameter int LOCK_WINS  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [15:0] real_in,
  input  logic signed [15:0] imag_in,
  input  logic               agc_en,
  input  logic [11:0]        gain_manual,
  output logic               out_valid,
  output logic [2:0]         real_out,
  output logic [2:0]         imag_out,
  output logic [11:0]        gain_out,
  output logic               agc_locked
);
  localparam int HW = WIN_LOG2 + 2;
  localparam logic [11:0] G_STEP = 12'(GAIN_STEP);
  localparam logic [11:0] G_TOP = 12'(4095 - GAIN_STEP);
  localparam logic [HW-1:0] HIT_HI = HW'(TARGET_CNT + HYST);
  localparam logic [HW-1:0] HIT_LO = HW'(TARGET_CNT - HYST);
  localparam logic [2:0] L_WINS = 3'(LOCK_WINS);
  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;
  state_t r_state, w_state_nx;
  logic r_v1, r_v2, r_ov;
  logic signed [15:0] r_re1, r_im1;
  logic signed [28:0] r_pre, r_pim, w_g;
  logic [2:0] r_qre, r_qim, r_lock, w_lock_nx, w_lock_inc;
  logic [11:0] r_gain, w_gain_nx;
  logic [WIN_LOG2-1:0] r_win, w_win_nx;
  logic [HW-1:0] r_hit, w_hit_nx, w_hit_tot;
  logic w_end, w_hi, w_lo;
  // |y| is taken at full 29-bit width so -32768 * 4095 cannot wrap positive
  function automatic logic [2:0] quant(input logic signed [28:0] p);
    logic signed [28:0] y;
    logic [28:0] a, m;
    y = p >>> 8;
    a = y[28] ? -y : y;
    m = a >> THR_SHIFT;
    return {y[28], (m > 29'd3) ? 2'd3 : m[1:0]};
  endfunction
  assign w_g = 29'(signed'({1'b0, r_gain}));
  assign w_hit_tot = r_hit + HW'(r_qre[1]) + HW'(r_qim[1]);
  assign w_end = r_ov && (r_win == '1);
  assign w_hi = w_hit_tot > HIT_HI;
  assign w_lo = w_hit_tot < HIT_LO;
  assign w_lock_inc = r_lock + 3'd1;
  assign out_valid = r_ov;
  assign real_out = r_qre;
  assign imag_out = r_qim;
  assign gain_out = r_gain;
  assign agc_locked = r_state == TRACK;
  // agc_en low wins over everything, including a window end in the same cycle
  always_comb begin
    w_state_nx = r_state;
    w_gain_nx = r_gain;
    w_win_nx = r_win;
    w_hit_nx = r_hit;
    w_lock_nx = r_lock;
    if (!agc_en) begin
      w_state_nx = IDLE;
      w_gain_nx = gain_manual;
      w_win_nx = '0;
      w_hit_nx = '0;
      w_lock_nx = '0;
    end else if (r_state == IDLE) begin
      w_state_nx = ACQUIRE;
    end else if (r_ov) begin
      w_win_nx = r_win + 1'b1;
      w_hit_nx = w_end ? '0 : w_hit_tot;
      if (w_end && (w_hi || w_lo)) begin
        w_gain_nx = w_hi ? ((r_gain > G_STEP) ? r_gain - G_STEP : 12'd1)
                         : ((r_gain > G_TOP) ? 12'hfff : r_gain + G_STEP);
        w_lock_nx = '0;
        w_state_nx = ACQUIRE;
      end else if (w_end && r_state == ACQUIRE) begin
        w_lock_nx = w_lock_inc;
        w_state_nx = (w_lock_inc == L_WINS) ? TRACK : ACQUIRE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_ov <= 1'b0;
      r_re1 <= '0;
      r_im1 <= '0;
      r_pre <= '0;
      r_pim <= '0;
      r_qre <= '0;
      r_qim <= '0;
      r_state <= IDLE;
      r_gain <= 12'(GAIN_INIT);
      r_win <= '0;
      r_hit <= '0;
      r_lock <= '0;
    end else begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_ov <= r_v2;
      if (in_valid) begin
        r_re1 <= real_in;
        r_im1 <= imag_in;
      end
      if (r_v1) begin
        r_pre <= 29'(r_re1) * w_g;
        r_pim <= 29'(r_im1) * w_g;
      end
      if (r_v2) begin
        r_qre <= quant(r_pre);
        r_qim <= quant(r_pim);
      end
      r_state <= w_state_nx;
      r_gain <= w_gain_nx;
      r_win <= w_win_nx;
      r_hit <= w_hit_nx;
      r_lock <= w_lock_nx;
    end
  end
endmodule
